// File: rtl/rx_capture_buffer_axil.sv
// Receive capture buffer: software-armed capture of AXI-Stream samples into a
// DEPTH-word buffer, read back word by word through an AXI4-Lite register port.
module rx_capture_buffer_axil #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int SAMPLE_WIDTH       = 32,
  parameter int DEPTH              = 1024
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [SAMPLE_WIDTH-1:0]         s_axis_tdata,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tuser,
  output logic                            s_axis_tready,
  output logic                            capture_done
);
  // state      | meaning
  // IDLE       | not capturing; waits for ARM
  // WAIT_TRIG  | armed, waiting for a tuser-marked sample
  // CAPTURE    | storing every valid sample until len_q reached
  // DONE       | capture complete; ARM re-arms

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_TRIG, ST_CAPTURE, ST_DONE} state_t;

  function automatic logic [31:0] strb_merge(input logic [31:0] cur, input logic [31:0] d,
                                             input logic [3:0] s);
    logic [31:0] r;
    r = cur;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  logic [SAMPLE_WIDTH-1:0] mem [DEPTH];
  logic [SAMPLE_WIDTH-1:0] mem_q;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  len_q, len_d, cnt_q, cnt_d, len_reg, len_new;
  logic              trunc_q, trunc_d, trig_mode, busy;
  logic              mem_we;
  logic [PTR_W-1:0]  mem_waddr, rd_ptr;
  logic [31:0]       scratch, len_merged, ptr_merged, reg_rdata, reg_rdata_q, cnt_ext;
  logic [15:0]       cnt_field;

  logic              aw_rdy_q, b_vld_q, ar_rdy_q, rd_pend_q, r_vld_q, rd_mem_q;
  logic [2:0]        wr_word, rd_word_q;
  logic              wr_hs, ar_hs, r_hs, ctrl_wr, arm, abort;
  logic              unused_ok;

  assign wr_hs   = aw_rdy_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign ar_hs   = ar_rdy_q & S_AXI_ARVALID;
  assign r_hs    = r_vld_q & S_AXI_RREADY;
  assign wr_word = S_AXI_AWADDR[4:2];
  assign ctrl_wr = wr_hs && (wr_word == 3'd0) && S_AXI_WSTRB[0];
  assign arm     = ctrl_wr & S_AXI_WDATA[0];
  assign abort   = ctrl_wr & S_AXI_WDATA[1];

  assign len_merged = strb_merge(32'(len_reg), S_AXI_WDATA, S_AXI_WSTRB);
  assign ptr_merged = strb_merge(32'(rd_ptr), S_AXI_WDATA, S_AXI_WSTRB);
  // Out-of-range lengths (0 or beyond the buffer) mean "fill the whole buffer".
  assign len_new = (len_merged == 32'd0 || len_merged > 32'(DEPTH)) ? DEPTH_C
                                                                    : len_merged[CNT_W-1:0];

  assign busy      = (state_q == ST_WAIT_TRIG) || (state_q == ST_CAPTURE);
  assign cnt_ext   = 32'(cnt_q);
  assign cnt_field = (cnt_ext > 32'h0000_FFFF) ? 16'hFFFF : cnt_ext[15:0];

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= ST_IDLE;
      len_q   <= DEPTH_C;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    trunc_d   = trunc_q;
    mem_we    = 1'b0;
    mem_waddr = cnt_q[PTR_W-1:0];
    if (abort) begin
      if (busy) begin
        state_d = ST_IDLE;
        trunc_d = 1'b1;
      end
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: if (arm) begin
          len_d   = len_reg;
          cnt_d   = '0;
          trunc_d = 1'b0;
          state_d = S_AXI_WDATA[2] ? ST_WAIT_TRIG : ST_CAPTURE;
        end
        ST_WAIT_TRIG: if (s_axis_tvalid && s_axis_tuser) begin
          mem_we    = 1'b1;
          mem_waddr = '0;
          cnt_d     = CNT_W'(1);
          state_d   = (len_q == CNT_W'(1)) ? ST_DONE : ST_CAPTURE;
        end
        ST_CAPTURE: if (s_axis_tvalid) begin
          mem_we = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_d == len_q) state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (mem_we) mem[mem_waddr] <= s_axis_tdata;
    if (rd_pend_q) mem_q <= mem[rd_ptr];
  end

  always_comb begin
    reg_rdata = 32'd0;
    case (rd_word_q)
      3'd0: reg_rdata = {29'd0, trig_mode, 2'b00};
      3'd1: reg_rdata = 32'(len_reg);
      3'd2: reg_rdata = {cnt_field, 13'd0, trunc_q, (state_q == ST_DONE), busy};
      3'd3: reg_rdata = 32'(rd_ptr);
      3'd5: reg_rdata = scratch;
      default: reg_rdata = 32'd0;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_rdy_q    <= 1'b0;
      b_vld_q     <= 1'b0;
      ar_rdy_q    <= 1'b0;
      rd_pend_q   <= 1'b0;
      r_vld_q     <= 1'b0;
      rd_mem_q    <= 1'b0;
      rd_word_q   <= 3'd0;
      reg_rdata_q <= 32'd0;
      len_reg     <= DEPTH_C;
      rd_ptr      <= '0;
      scratch     <= 32'd0;
      trig_mode   <= 1'b0;
    end else begin
      aw_rdy_q  <= S_AXI_AWVALID && S_AXI_WVALID && !b_vld_q && !aw_rdy_q;
      if (wr_hs) b_vld_q <= 1'b1;
      else if (S_AXI_BREADY) b_vld_q <= 1'b0;

      ar_rdy_q  <= S_AXI_ARVALID && !ar_rdy_q && !rd_pend_q && !r_vld_q;
      rd_pend_q <= ar_hs;
      if (ar_hs) rd_word_q <= S_AXI_ARADDR[4:2];
      // One cycle after AR for the synchronous buffer read, then RVALID.
      if (rd_pend_q) begin
        r_vld_q     <= 1'b1;
        reg_rdata_q <= reg_rdata;
        rd_mem_q    <= (rd_word_q == 3'd4);
      end else if (r_hs) begin
        r_vld_q <= 1'b0;
      end
      if (r_hs && rd_mem_q) rd_ptr <= rd_ptr + 1'b1;

      if (wr_hs) begin
        case (wr_word)
          3'd0: if (S_AXI_WSTRB[0]) trig_mode <= S_AXI_WDATA[2];
          3'd1: len_reg <= len_new;
          3'd3: rd_ptr  <= ptr_merged[PTR_W-1:0];
          3'd5: scratch <= strb_merge(scratch, S_AXI_WDATA, S_AXI_WSTRB);
          default: ;
        endcase
      end
    end
  end

  assign S_AXI_AWREADY = aw_rdy_q;
  assign S_AXI_WREADY  = aw_rdy_q;
  assign S_AXI_BVALID  = b_vld_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = ar_rdy_q;
  assign S_AXI_RVALID  = r_vld_q;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RDATA   = rd_mem_q ? 32'(mem_q) : reg_rdata_q;
  assign s_axis_tready = 1'b1;
  assign capture_done  = (state_q == ST_DONE);

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                       ptr_merged[31:PTR_W]};
endmodule

// File: doc/rx_capture_buffer_axil.md
# rx_capture_buffer_axil

AXI4-Lite-controlled receive capture buffer, the parametrised successor of the fixed four-register RX buffer slave. A software-armed state machine captures a programmable number of AXI-Stream samples into an internal buffer of DEPTH words. The captured data is then read back word by word through the AXI4-Lite register port. The block sits between the RX datapath stream and the PS-side AXI4-Lite interconnect.

## Interface
- C_S_AXI_DATA_WIDTH, 32, AXI4-Lite data width; fixed at 32.
- C_S_AXI_ADDR_WIDTH, 5, byte address width; decodes 8 word registers.
- SAMPLE_WIDTH, 32, stream sample width, 1..32; zero-extended on readback.
- DEPTH, 1024, buffer depth in samples; power of two, 16..65536.

Ports:
- ACLK  in  1  single clock.
- ARESETN  in  1  reset; asynchronous assert, active-low.
- S_AXI_AW*/W*/B*/AR*/R*  AXI4-Lite slave, standard signal set, C_S_AXI_ADDR_WIDTH/32 bits; BRESP/RRESP are always OKAY.
- s_axis_tdata  in  SAMPLE_WIDTH  RX sample.
- s_axis_tvalid  in  1  sample valid.
- s_axis_tuser  in  1  start-of-frame marker.
- s_axis_tready  out  1  tied to 1; the stream is never back-pressured.
- capture_done  out  1  level; high in DONE.

## Operation
Register map (byte offsets):
- 0x00 CTRL (write-only, self-clearing): bit0 ARM, bit1 ABORT, bit2 TRIG_MODE (sticky, readable). TRIG_MODE=0 starts immediately; TRIG_MODE=1 waits for tuser.
- 0x04 LEN (RW): capture length. A value of 0 or a value greater than DEPTH is stored as DEPTH.
- 0x08 STATUS (RO): bit0 busy (WAIT_TRIG or CAPTURE), bit1 done, bit2 truncated (aborted), [31:16] captured count. Count saturates at 0xFFFF in the field only.
- 0x0C RD_PTR (RW): buffer read index, log2(DEPTH) bits; wraps modulo DEPTH.
- 0x10 RD_DATA (RO): returns buffer[RD_PTR], then increments RD_PTR modulo DEPTH.
- 0x14 SCRATCH (RW): full 32 bits, WSTRB honoured per byte.
- 0x18, 0x1C: read 0, writes ignored.

WSTRB is honoured on LEN, RD_PTR and SCRATCH. CTRL acts only when WSTRB[0]=1.

State machine:
- IDLE: on ARM, latch LEN into len_q, clear count/done/truncated, set write address 0. Go to WAIT_TRIG if TRIG_MODE=1, else CAPTURE.
- WAIT_TRIG: on tvalid && tuser, store that sample at address 0, count=1, go to CAPTURE. If len_q==1, go directly to DONE.
- CAPTURE: each tvalid writes tdata at address count and increments count. When count reaches len_q, go to DONE.
- DONE: done=1. ARM re-arms exactly as from IDLE.
- ABORT in WAIT_TRIG or CAPTURE: go to IDLE with truncated=1 and count retained.

Rules:
- ARM while busy is ignored.
- ABORT and ARM in the same write: ABORT wins.
- Writes to LEN while busy update the register but not len_q.
- RD_DATA reads while busy are allowed; contents may be partially updated.
- Samples outside CAPTURE are dropped, except the trigger sample.
- Reset returns to IDLE. Buffer contents are not cleared.

## Timing
- Reset values: all AXI ready/valid outputs 0; LEN=DEPTH; RD_PTR=0; SCRATCH=0; TRIG_MODE=0; STATUS=0; capture_done=0; s_axis_tready=1.
- Write channel:
  - AWREADY and WREADY pulse together for one cycle once both AWVALID and WVALID are high and BVALID is low.
  - BVALID rises the following cycle and holds until BREADY.
  - Register effects are visible from the cycle after the handshake.
- Read channel:
  - ARREADY pulses for one cycle when ARVALID is high and RVALID is low.
  - RVALID rises 2 cycles after the AR handshake for every address (synchronous buffer read) and holds until RREADY.
  - The RD_PTR increment occurs on the RREADY&&RVALID cycle.
- Only one outstanding read and one outstanding write are allowed; reads and writes proceed independently.
- Capture: a sample accepted in cycle t is readable from cycle t+1. Transition to DONE in the cycle after the last sample; capture_done rises in that same cycle.
- ARM write handshake at cycle t: state leaves IDLE at t+1; the first sample accepted is at t+1 or later.

## Test plan
- Reset, then read all 8 offsets -> 0,0,0x400(LEN=DEPTH, write-only CTRL reads 0),... exactly: 0x00=0, 0x04=0x400, 0x08=0, 0x0C=0, 0x14=0, 0x18=0; DEPTH=1024.
- SCRATCH=0xA5A5A5A5, then write 0x00001100 with WSTRB=0b0010 -> readback 0xA5A511A5.
- LEN=4, ARM; stream 1,2,3,4,5 -> STATUS=0x00040002, capture_done=1; RD_PTR=0 then 4 RD_DATA reads -> 1,2,3,4; RD_PTR reads 4.
- TRIG_MODE=1, LEN=3, ARM; stream 9 (tuser=0), 7 (tuser=1), 8, 6 -> buffer[0..2]=7,8,6, done.
- LEN=100, ARM, 10 samples, then ABORT|ARM in one write -> STATUS=0x000A0004, state IDLE.
- RD_PTR=DEPTH-1, two RD_DATA reads -> RD_PTR wraps to 1. Also: deassert ARESETN mid-capture -> capture_done=0 and STATUS=0 asynchronously.
